// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared types for the two-requester PicoRV32 memory arbiter.
// Round-robin tie-break is enabled with PICORV_ARB_ROUND_ROBIN_EN.
package picorv_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } arb_state_e;

  typedef struct packed {
    logic                      instr;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0]     wdata;
    logic [DATA_W_DEF/8-1:0]   wstrb;
  } mem_req_t;

endpackage

// File: rtl/picorv32_mem_arbiter_if.sv
// PicoRV32-native memory port: valid/ready handshake plus request
// fields and read data. Master issues requests, slave answers them.
interface picorv32_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              instr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/picorv32_mem_arbiter_pick.sv
// Winner select for the memory arbiter. Tie-break mode is chosen by
// PICORV_ARB_ROUND_ROBIN_EN (defined: alternate, else req 0 wins).
module picorv_arb_pick (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic any,
  output logic gnt
);

  assign any = v0 | v1;

`ifdef PICORV_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (v0 & v1):  gnt = ~last;
      (v1 & ~v0): gnt = 1'b1;
      default:    gnt = 1'b0;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign gnt = v1 & ~v0;
`endif

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Two-to-one PicoRV32 memory port arbiter: one whole transfer per grant.
// Tie-break selected by PICORV_ARB_ROUND_ROBIN_EN (see picorv_arb_pick).
module picorv32_mem_arbiter
  import picorv_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  picorv32_mem_arbiter_if.slave  m0,
  picorv32_mem_arbiter_if.slave  m1,
  picorv32_mem_arbiter_if.master mem,
  output logic                   arb_busy,
  output logic                   arb_owner,
  output logic [CNT_W-1:0]       gnt_cnt0,
  output logic [CNT_W-1:0]       gnt_cnt1
);

  arb_state_e       state;
  mem_req_t         req;
  mem_req_t         win;
  logic             valid_q;
  logic             busy_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             any;
  logic             pick;
  logic             done_hit;

  picorv_arb_pick u_pick (
    .v0   (m0.valid),
    .v1   (m1.valid),
    .last (owner_q),
    .any  (any),
    .gnt  (pick)
  );

  always_comb begin
    win = '0;
    if (pick) begin
      win.instr = m1.instr;
      win.addr  = m1.addr;
      win.wdata = m1.wdata;
      win.wstrb = m1.wstrb;
    end else begin
      win.instr = m0.instr;
      win.addr  = m0.addr;
      win.wdata = m0.wdata;
      win.wstrb = m0.wstrb;
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      req     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            req     <= win;
            owner_q <= pick;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= GRANT;
            if (pick) begin
              if (~&cnt1_q) cnt1_q <= cnt1_q + 1'b1;
            end else begin
              if (~&cnt0_q) cnt0_q <= cnt0_q + 1'b1;
            end
          end
        end
        GRANT: begin
          if (mem.ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done_hit  = (state == GRANT) & mem.ready;

  assign m0.ready  = done_hit & ~owner_q;
  assign m1.ready  = done_hit & owner_q;
  assign m0.rdata  = m0.ready ? mem.rdata : '0;
  assign m1.rdata  = m1.ready ? mem.rdata : '0;

  assign mem.valid = valid_q;
  assign mem.instr = req.instr;
  assign mem.addr  = req.addr[ADDR_W-1:0];
  assign mem.wdata = req.wdata[DATA_W-1:0];
  assign mem.wstrb = req.wstrb[DATA_W/8-1:0];

  assign arb_busy  = busy_q;
  assign arb_owner = owner_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter: vector table plus corner
// sequences; expected owners follow PICORV_ARB_ROUND_ROBIN_EN.
module tb_picorv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arb_busy;
  logic        arb_owner;
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;

  always #5 clk = ~clk;

  picorv32_mem_arbiter_if m0_if ();
  picorv32_mem_arbiter_if m1_if ();
  picorv32_mem_arbiter_if mem_if ();

  picorv32_mem_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem       (mem_if),
    .arb_busy  (arb_busy),
    .arb_owner (arb_owner),
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
  );

  typedef struct {
    logic        v0, v1, i0, i1;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0]  s0, s1;
    logic [31:0] rd;
    logic        own;
  } vec_t;

  vec_t        tbl[7];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] e_cnt0 = 0;
  logic [15:0] e_cnt1 = 0;

  function automatic vec_t mk(
    input logic v0, input logic v1,
    input logic i0, input logic i1,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] w0, input logic [31:0] w1,
    input logic [3:0] s0, input logic [3:0] s1,
    input logic [31:0] rd, input logic own);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.i0 = i0; v.i1 = i1;
    v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.s0 = s0; v.s1 = s1; v.rd = rd; v.own = own;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_if.valid = 0; m0_if.instr = 0; m0_if.addr = 0;
    m0_if.wdata = 0; m0_if.wstrb = 0;
    m1_if.valid = 0; m1_if.instr = 0; m1_if.addr = 0;
    m1_if.wdata = 0; m1_if.wstrb = 0;
    mem_if.ready = 0; mem_if.rdata = 0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(negedge clk);
    m0_if.valid = v.v0; m0_if.instr = v.i0; m0_if.addr = v.a0;
    m0_if.wdata = v.w0; m0_if.wstrb = v.s0;
    m1_if.valid = v.v1; m1_if.instr = v.i1; m1_if.addr = v.a1;
    m1_if.wdata = v.w1; m1_if.wstrb = v.s1;
    mem_if.ready = 0;
    @(negedge clk);
    if (v.own) e_cnt1++;
    else e_cnt0++;
    chk($sformatf("v%0d mem_valid", k), 32'(mem_if.valid), 1);
    chk($sformatf("v%0d busy", k), 32'(arb_busy), 1);
    chk($sformatf("v%0d owner", k), 32'(arb_owner), 32'(v.own));
    chk($sformatf("v%0d addr", k), mem_if.addr, v.own ? v.a1 : v.a0);
    chk($sformatf("v%0d wdata", k), mem_if.wdata, v.own ? v.w1 : v.w0);
    chk($sformatf("v%0d wstrb", k), 32'(mem_if.wstrb),
        32'(v.own ? v.s1 : v.s0));
    chk($sformatf("v%0d instr", k), 32'(mem_if.instr),
        32'(v.own ? v.i1 : v.i0));
    chk($sformatf("v%0d cnt0", k), 32'(gnt_cnt0), 32'(e_cnt0));
    chk($sformatf("v%0d cnt1", k), 32'(gnt_cnt1), 32'(e_cnt1));
    chk($sformatf("v%0d early_rdy", k),
        32'({m0_if.ready, m1_if.ready}), 0);
    mem_if.ready = 1; mem_if.rdata = v.rd;
    #1;
    chk($sformatf("v%0d own_rdy", k),
        32'(v.own ? m1_if.ready : m0_if.ready), 1);
    chk($sformatf("v%0d own_rdata", k),
        v.own ? m1_if.rdata : m0_if.rdata, v.rd);
    chk($sformatf("v%0d oth_rdy", k),
        32'(v.own ? m0_if.ready : m1_if.ready), 0);
    chk($sformatf("v%0d oth_rdata", k),
        v.own ? m0_if.rdata : m1_if.rdata, 0);
    @(negedge clk);
    mem_if.ready = 0;
    if (v.own) m1_if.valid = 0;
    else m0_if.valid = 0;
    #1;
    chk($sformatf("v%0d done_valid", k), 32'(mem_if.valid), 0);
    chk($sformatf("v%0d done_busy", k), 32'(arb_busy), 0);
    chk($sformatf("v%0d done_rdy", k),
        32'({m0_if.ready, m1_if.ready}), 0);
  endtask

  initial begin
    logic [3:0] tie_own;
`ifdef PICORV_ARB_ROUND_ROBIN_EN
    tie_own = 4'b1010;
`else
    tie_own = 4'b0000;
`endif
    tbl[0] = mk(1, 0, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 32'h0,
                4'h0, 4'h0, 32'hAAAA_FFFF, 0);
    tbl[1] = mk(0, 1, 0, 0, 32'h0, 32'h8000_0000, 32'h0, 32'hF0FF_0FAA,
                4'h0, 4'hC, 32'h5555_0000, 1);
    for (int i = 0; i < 4; i++)
      tbl[2+i] = mk(1, 1, 1, 0, 32'h100, 32'h200, 32'h0, 32'hDEAD_BEEF,
                    4'h0, 4'hF, 32'h1000 + 32'(i), tie_own[i]);
    tbl[6] = mk(1, 0, 1, 0, 32'h10, 32'h0, 32'h0, 32'h0,
                4'h0, 4'h0, 32'h13, 0);

    resetn = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst mem_valid", 32'(mem_if.valid), 0);
    chk("rst mem_addr", mem_if.addr, 0);
    chk("rst mem_wdata", mem_if.wdata, 0);
    chk("rst mem_wstrb", 32'(mem_if.wstrb), 0);
    chk("rst mem_instr", 32'(mem_if.instr), 0);
    chk("rst busy", 32'(arb_busy), 0);
    chk("rst owner", 32'(arb_owner), 0);
    chk("rst cnt", {gnt_cnt1, gnt_cnt0}, 0);
    chk("rst ready", 32'({m0_if.ready, m1_if.ready}), 0);
    resetn = 1;

    @(negedge clk);
    mem_if.ready = 1; mem_if.rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_mrdy ready", 32'({m0_if.ready, m1_if.ready}), 0);
    chk("idle_mrdy rdata", m0_if.rdata, 0);
    @(negedge clk);
    chk("idle_mrdy valid", 32'(mem_if.valid), 0);
    chk("idle_mrdy busy", 32'(arb_busy), 0);
    mem_if.ready = 0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    @(negedge clk);
    m0_if.valid = 1; m0_if.addr = 32'h100;
    m0_if.wdata = 32'h55; m0_if.wstrb = 4'hF; m0_if.instr = 0;
    @(negedge clk);
    e_cnt0++;
    chk("latch addr0", mem_if.addr, 32'h100);
    m0_if.addr = 32'h1234; m0_if.wdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("latch addr%0d", i + 1), mem_if.addr, 32'h100);
      chk($sformatf("latch wdata%0d", i + 1), mem_if.wdata, 32'h55);
      chk($sformatf("stuck valid%0d", i + 1), 32'(mem_if.valid), 1);
    end
    m0_if.valid = 0;
    @(negedge clk);
    chk("drop valid_hold", 32'(mem_if.valid), 1);
    mem_if.ready = 1; mem_if.rdata = 32'h7777_0001;
    #1;
    chk("drop rdy", 32'(m0_if.ready), 1);
    chk("drop rdata", m0_if.rdata, 32'h7777_0001);
    @(negedge clk);
    mem_if.ready = 0;
    chk("latch done_valid", 32'(mem_if.valid), 0);
    chk("latch done_addr", mem_if.addr, 32'h100);
    chk("latch cnt0", 32'(gnt_cnt0), 32'(e_cnt0));

    @(negedge clk);
    m0_if.valid = 1; m0_if.addr = 32'h40; m0_if.wstrb = 4'h0;
    @(negedge clk);
    chk("midrst pre_valid", 32'(mem_if.valid), 1);
    resetn = 0;
    #1;
    chk("midrst valid", 32'(mem_if.valid), 0);
    chk("midrst busy", 32'(arb_busy), 0);
    chk("midrst cnt", {gnt_cnt1, gnt_cnt0}, 0);
    chk("midrst addr", mem_if.addr, 0);
    mem_if.ready = 1; mem_if.rdata = 32'h1;
    #1;
    chk("midrst no_rdy", 32'({m0_if.ready, m1_if.ready}), 0);
    @(negedge clk);
    resetn = 1;
    idle_inputs();
    e_cnt0 = 0; e_cnt1 = 0;
    run_vec(mk(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0,
               4'h0, 4'h0, 32'hCAFE_0040, 0), 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
